// File: rtl/rx_test_sequencer.sv
// rx_test_sequencer: runs one BER measurement on the receive bit path under
// UART command control, then returns an 8-byte result frame over valid/ready.
// Frame: A5, err_count[23:0], bit_cnt[23:0], XOR of the 6 payload bytes.
// Optional build macro RX_SEQ_ALIGN_EN adds a HUNT state that waits until
// the incoming bit stream lines up with the pattern before counting starts.
module rx_test_sequencer #(
  parameter int                   CNT_W       = 20,
  parameter int                   PATTERN_W   = 8,
  parameter logic [PATTERN_W-1:0] DEF_PATTERN = 8'h55,
  parameter logic [CNT_W-1:0]     DEF_COUNT   = 20'd900000,
  parameter int                   ARG_TO      = 25000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             from_uart_valid,
  input  logic [7:0]       from_uart_data,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic [7:0]       to_uart_data,
  output logic             to_uart_valid,
  input  logic             to_uart_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0] CMD_P   = 8'h50;
  localparam logic [7:0] CMD_C   = 8'h43;
  localparam logic [7:0] CMD_S   = 8'h53;
  localparam logic [7:0] CMD_A   = 8'h41;
  localparam logic [7:0] HEADER  = 8'hA5;
  localparam int         IDX_W   = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam int         TO_W    = $clog2(ARG_TO + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
`ifdef RX_SEQ_ALIGN_EN
    ST_HUNT,
`endif
    ST_RUN,
    ST_SEND
  } state_t;

  state_t               state;
  logic [PATTERN_W-1:0] pattern;
  logic [CNT_W-1:0]     max_count;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 arg_is_cnt;  // 1: collecting 'C' bytes, 0: 'P' byte
  logic [1:0]           arg_left;    // argument bytes still expected
  logic [15:0]          arg_buf;     // earlier argument bytes, oldest first
  logic [TO_W-1:0]      to_cnt;
  logic [3:0]           byte_idx;    // frame bytes loaded into to_uart_data
`ifdef RX_SEQ_ALIGN_EN
  logic [PATTERN_W-1:0] hunt_sr;
  logic [PATTERN_W-1:0] hunt_sr_next;
`endif

  logic             abort;
  logic             exp_bit;
  logic [CNT_W-1:0] bit_cnt_inc;
  logic [23:0]      err24;
  logic [23:0]      cnt24;
  logic [7:0]       checksum;
  logic [7:0]       frame_byte;

  assign abort       = from_uart_valid && (from_uart_data == CMD_A);
  assign exp_bit     = pattern[LAST_IDX - bit_idx];
  assign bit_cnt_inc = bit_cnt + 1'b1;
  assign err24       = 24'(err_count);
  assign cnt24       = 24'(bit_cnt);
  assign checksum    = err24[23:16] ^ err24[15:8] ^ err24[7:0] ^
                       cnt24[23:16] ^ cnt24[15:8] ^ cnt24[7:0];
`ifdef RX_SEQ_ALIGN_EN
  assign hunt_sr_next = {hunt_sr[PATTERN_W-2:0], bit_data};
`endif

  // Select the frame byte that will be loaded next.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    frame_byte = checksum;
    case (byte_idx[2:0])
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = err24[23:16];
      3'd2:    frame_byte = err24[15:8];
      3'd3:    frame_byte = err24[7:0];
      3'd4:    frame_byte = cnt24[23:16];
      3'd5:    frame_byte = cnt24[15:8];
      3'd6:    frame_byte = cnt24[7:0];
      default: frame_byte = checksum;
    endcase
  end

  // Command parser, measurement FSM and frame transmitter with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order in this block.
    if (rst) begin
      state         <= ST_IDLE;
      pattern       <= DEF_PATTERN;
      max_count     <= DEF_COUNT;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      err_count     <= '0;
      arg_is_cnt    <= 1'b0;
      arg_left      <= '0;
      arg_buf       <= '0;
      to_cnt        <= '0;
      byte_idx      <= '0;
      to_uart_data  <= '0;
      to_uart_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef RX_SEQ_ALIGN_EN
      hunt_sr       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (from_uart_valid) begin
            case (from_uart_data)
              CMD_P: begin
                state      <= ST_ARG;
                busy       <= 1'b1;
                arg_is_cnt <= 1'b0;
                arg_left   <= 2'd1;
                to_cnt     <= '0;
              end
              CMD_C: begin
                state      <= ST_ARG;
                busy       <= 1'b1;
                arg_is_cnt <= 1'b1;
                arg_left   <= 2'd3;
                to_cnt     <= '0;
              end
              CMD_S: begin
                if (max_count != '0) begin
                  bit_cnt   <= '0;
                  err_count <= '0;
                  bit_idx   <= '0;
                  busy      <= 1'b1;
`ifdef RX_SEQ_ALIGN_EN
                  hunt_sr   <= '0;
                  state     <= ST_HUNT;
`else
                  state     <= ST_RUN;
`endif
                end
              end
              default: ;
            endcase
          end
        end

        ST_ARG: begin
          if (from_uart_valid) begin
            to_cnt  <= '0;
            arg_buf <= {arg_buf[7:0], from_uart_data};
            if (arg_left == 2'd1) begin
              if (arg_is_cnt) max_count <= CNT_W'({arg_buf, from_uart_data});
              else            pattern   <= PATTERN_W'(from_uart_data);
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              arg_left <= arg_left - 2'd1;
            end
          end else if (to_cnt == TO_W'(ARG_TO - 1)) begin
            // Argument stream stalled: drop the partial argument.
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

`ifdef RX_SEQ_ALIGN_EN
        ST_HUNT: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (bit_valid) begin
            hunt_sr <= hunt_sr_next;
            if (hunt_sr_next == pattern) begin
              state   <= ST_RUN;
              bit_idx <= '0;
            end
          end
        end
`endif

        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (bit_valid) begin
            bit_cnt <= bit_cnt_inc;
            bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
            if (bit_data != exp_bit) err_count <= err_count + 1'b1;
            if (bit_cnt_inc == max_count) begin
              state    <= ST_SEND;
              byte_idx <= '0;
            end
          end
        end

        ST_SEND: begin
          if (abort) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            to_uart_valid <= 1'b0;
          end else if (!to_uart_valid) begin
            to_uart_data  <= frame_byte;
            to_uart_valid <= 1'b1;
            byte_idx      <= byte_idx + 1'b1;
          end else if (to_uart_ready) begin
            if (byte_idx == 4'd8) begin
              to_uart_valid <= 1'b0;
              done          <= 1'b1;
              busy          <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              to_uart_data <= frame_byte;
              byte_idx     <= byte_idx + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
